fix_to_float: RTL and testbench

- Sequential converter from signed two's-complement fixed-point to IEEE-754-style binary float. It is the inverse path of the float-to-fixed converter.
- Fixed-point LSB weight is 2^-(BIAS+MANT_W-1), where MANT_W = EXP_LSB_POS and BIAS = 2^(EXP_MSB_POS-EXP_LSB_POS)-1. For half precision this is 2^-24.
- Normalisation is iterative (one shift step per cycle). Rounding is round-to-nearest-even (RNE).
- Sits behind fixed-point accumulators: valid/ready on input, valid/ready on output.

---
 rtl/fix_to_float_pkg.sv | 37 +++
 rtl/fix_to_float_rounder.sv | 65 ++++++
 rtl/fix_to_float.sv | 137 +++++++++++++
 tb/tb_fix_to_float.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/fix_to_float_pkg.sv
// fix_to_float_pkg: shared types and float-format constants for the
// fixed-point to float converter.
//   state_e   : converter FSM states
//   MANT_W    : mantissa field width
//   EXP_W     : exponent field width
//   BIAS      : exponent bias
//   EXP_MAX   : largest finite biased exponent
//   INF_EXP   : biased exponent encoding infinity
//   rne_round : round-to-nearest-even on a mantissa, returns {carry, mant}
package fix_to_float_pkg;

  localparam int EXP_MSB_POS_DEF = 14;
  localparam int EXP_LSB_POS_DEF = 10;
  localparam int FIXED_W_DEF     = 80;

  localparam int MANT_W  = EXP_LSB_POS_DEF;
  localparam int EXP_W   = EXP_MSB_POS_DEF - EXP_LSB_POS_DEF + 1;
  localparam int BIAS    = (1 << (EXP_MSB_POS_DEF - EXP_LSB_POS_DEF)) - 1;
  localparam int INF_EXP = (1 << EXP_W) - 1;
  localparam int EXP_MAX = INF_EXP - 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    NORM  = 2'd1,
    ROUND = 2'd2,
    OUT   = 2'd3
  } state_e;

  function automatic logic [MANT_W:0] rne_round(input logic [MANT_W-1:0] mant,
                                                input logic              guard,
                                                input logic              sticky);
    logic up;
    up = guard & (sticky | mant[0]);
    return {1'b0, mant} + (MANT_W+1)'(up);
  endfunction

endpackage

// File: rtl/fix_to_float_rounder.sv
// fix_to_float_rounder: combinational pack/round/overflow stage used in the
// ROUND state.
//   sign_i     : operand sign
//   mag_i      : magnitude; normalised (MSB set) unless zero or denormal
//   sh_i       : number of left shifts applied during normalisation
//   result_o   : packed {sign, exp, mantissa}
//   overflow_o : result saturated to +/-inf
//   inexact_o  : guard or sticky nonzero (or overflow)
module fix_to_float_rounder
  import fix_to_float_pkg::*;
#(
  parameter int FIXED_W = FIXED_W_DEF,
  parameter int SH_W    = 7,
  parameter int FLOAT_W = EXP_MSB_POS_DEF + 2
) (
  input  logic               sign_i,
  input  logic [FIXED_W-1:0] mag_i,
  input  logic [SH_W-1:0]    sh_i,
  output logic [FLOAT_W-1:0] result_o,
  output logic               overflow_o,
  output logic               inexact_o
);

  // Wide enough for the largest unbiased position plus the rounding carry.
  localparam int EXP_CALC_W = $clog2(FIXED_W) + 2;
  // Fixed-point LSB sits at 2^-(BIAS+MANT_W-1).
  localparam int FRAC_BITS  = BIAS + MANT_W - 1;

  logic [EXP_CALC_W-1:0] exp_calc;
  logic [MANT_W-1:0]     mant;
  logic                  guard;
  logic                  sticky;
  logic [MANT_W:0]       rounded;

  always_comb begin
    result_o   = '0;
    overflow_o = 1'b0;
    inexact_o  = 1'b0;
    mant       = mag_i[FIXED_W-2 -: MANT_W];
    guard      = mag_i[FIXED_W-2-MANT_W];
    sticky     = |mag_i[FIXED_W-3-MANT_W:0];
    rounded    = rne_round(mant, guard, sticky);
    // Leading one sits at FIXED_W-1-sh; its unbiased exponent is that minus
    // FRAC_BITS, then rebias.
    exp_calc   = EXP_CALC_W'(FIXED_W - 1 - FRAC_BITS + BIAS) - EXP_CALC_W'(sh_i);
    if (rounded[MANT_W]) begin
      exp_calc = exp_calc + EXP_CALC_W'(1);
    end

    if (mag_i == '0) begin
      result_o = '0;
    end else if (mag_i[FIXED_W-1:MANT_W] == '0) begin
      // Denormal: magnitude fits the mantissa field directly, no rounding.
      result_o = {sign_i, {EXP_W{1'b0}}, mag_i[MANT_W-1:0]};
    end else if (exp_calc > EXP_CALC_W'(EXP_MAX)) begin
      result_o   = {sign_i, EXP_W'(INF_EXP), {MANT_W{1'b0}}};
      overflow_o = 1'b1;
      inexact_o  = 1'b1;
    end else begin
      result_o  = {sign_i, exp_calc[EXP_W-1:0], rounded[MANT_W-1:0]};
      inexact_o = guard | sticky;
    end
  end

endmodule

// File: rtl/fix_to_float.sv
// fix_to_float: sequential signed fixed-point to binary float converter with
// iterative normalisation and round-to-nearest-even.
//   clk_i, rst_i          : clock, async active-high reset
//   in_valid_i/in_ready_o : operand handshake (ready only in IDLE)
//   fixed_point_value_i   : signed two's-complement operand
//   out_valid_o/out_ready_i : result handshake
//   float_point_operand_o : {sign, exp, mantissa}
//   overflow_flag_o       : result saturated to +/-inf
//   inexact_flag_o        : rounding discarded nonzero bits
// Build option: FIX_TO_FLOAT_FAST_NORM_EN enables 8-bit normalisation steps.
module fix_to_float
  import fix_to_float_pkg::*;
#(
  parameter int EXP_MSB_POS    = EXP_MSB_POS_DEF,
  parameter int EXP_LSB_POS    = EXP_LSB_POS_DEF,
  parameter int FLOAT_OP_WIDTH = EXP_MSB_POS + 2,
  parameter int FIXED_OP_WIDTH = FIXED_W_DEF
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      in_valid_i,
  output logic                      in_ready_o,
  input  logic [FIXED_OP_WIDTH-1:0] fixed_point_value_i,
  output logic                      out_valid_o,
  input  logic                      out_ready_i,
  output logic [FLOAT_OP_WIDTH-1:0] float_point_operand_o,
  output logic                      overflow_flag_o,
  output logic                      inexact_flag_o
);

  localparam int W    = FIXED_OP_WIDTH;
  localparam int SH_W = $clog2(W);

  state_e                    state_q, state_d;
  logic                      sign_q, sign_d;
  logic [W-1:0]              mag_q, mag_d;
  logic [SH_W-1:0]           sh_q, sh_d;
  logic [FLOAT_OP_WIDTH-1:0] result_q, result_d;
  logic                      ovf_q, ovf_d;
  logic                      inex_q, inex_d;

  logic [W-1:0]              in_mag;
  logic [FLOAT_OP_WIDTH-1:0] rnd_result;
  logic                      rnd_ovf;
  logic                      rnd_inex;

  // Unsigned negate maps -2^(W-1) onto 2^(W-1) exactly.
  assign in_mag = fixed_point_value_i[W-1] ? (~fixed_point_value_i + W'(1))
                                           : fixed_point_value_i;

  fix_to_float_rounder #(
    .FIXED_W (W),
    .SH_W    (SH_W),
    .FLOAT_W (FLOAT_OP_WIDTH)
  ) u_rounder (
    .sign_i     (sign_q),
    .mag_i      (mag_q),
    .sh_i       (sh_q),
    .result_o   (rnd_result),
    .overflow_o (rnd_ovf),
    .inexact_o  (rnd_inex)
  );

  always_comb begin
    state_d  = state_q;
    sign_d   = sign_q;
    mag_d    = mag_q;
    sh_d     = sh_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    inex_d   = inex_q;
    case (state_q)
      IDLE: begin
        if (in_valid_i) begin
          sign_d  = fixed_point_value_i[W-1];
          mag_d   = in_mag;
          sh_d    = '0;
          // Zero and denormals bypass normalisation.
          state_d = (in_mag[W-1:EXP_LSB_POS] == '0) ? ROUND : NORM;
        end
      end
      NORM: begin
        if (mag_q[W-1]) begin
          state_d = ROUND;
`ifdef FIX_TO_FLOAT_FAST_NORM_EN
        end else if (mag_q[W-1 -: 8] == 8'd0 &&
                     (W - 1 - int'(sh_q)) >= EXP_LSB_POS + 8) begin
          mag_d = mag_q << 8;
          sh_d  = sh_q + SH_W'(8);
`endif
        end else begin
          mag_d = mag_q << 1;
          sh_d  = sh_q + SH_W'(1);
        end
      end
      ROUND: begin
        result_d = rnd_result;
        ovf_d    = rnd_ovf;
        inex_d   = rnd_inex;
        state_d  = OUT;
      end
      OUT: begin
        if (out_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      sign_q   <= 1'b0;
      mag_q    <= '0;
      sh_q     <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      inex_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sign_q   <= sign_d;
      mag_q    <= mag_d;
      sh_q     <= sh_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
      inex_q   <= inex_d;
    end
  end

  assign in_ready_o            = (state_q == IDLE);
  assign out_valid_o           = (state_q == OUT);
  assign float_point_operand_o = result_q;
  assign overflow_flag_o       = ovf_q;
  assign inexact_flag_o        = inex_q;

endmodule

// File: tb/tb_fix_to_float.sv
module tb_fix_to_float;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        in_valid_i = 1'b0;
  logic        in_ready_o;
  logic [79:0] fixed_point_value_i = '0;
  logic        out_valid_o;
  logic        out_ready_i = 1'b0;
  logic [15:0] float_point_operand_o;
  logic        overflow_flag_o;
  logic        inexact_flag_o;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk_i = ~clk_i;

  fix_to_float dut (
    .clk_i                 (clk_i),
    .rst_i                 (rst_i),
    .in_valid_i            (in_valid_i),
    .in_ready_o            (in_ready_o),
    .fixed_point_value_i   (fixed_point_value_i),
    .out_valid_o           (out_valid_o),
    .out_ready_i           (out_ready_i),
    .float_point_operand_o (float_point_operand_o),
    .overflow_flag_o       (overflow_flag_o),
    .inexact_flag_o        (inexact_flag_o)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Reference: value = x * 2^-24, rounded to nearest-even half precision.
  task automatic model(input logic [79:0] x, output logic [15:0] res,
                       output logic ovf, output logic inex, output int lat);
    logic [79:0] mag, m, r, half, one;
    int p, k, e, sh;
    one = 80'd1;
    mag = x[79] ? (~x + 80'd1) : x;
    ovf = 1'b0; inex = 1'b0; res = '0; lat = 2;
    if (mag == 0) begin
      res = '0;
    end else if (mag < 80'd1024) begin
      res = {x[79], 5'd0, mag[9:0]};
    end else begin
      p = 0;
      for (int i = 0; i < 80; i++) if (mag[i]) p = i;
      sh = 79 - p;
`ifdef FIX_TO_FLOAT_FAST_NORM_EN
      lat = sh / 8 + sh % 8 + 3;
`else
      lat = sh + 3;
`endif
      k = p - 10;
      m = mag >> k;
      r = mag - (m << k);
      half = (k > 0) ? (one << (k - 1)) : 80'd0;
      if (k > 0 && (r > half || (r == half && m[0]))) m = m + 80'd1;
      e = p - 9;
      if (m == 80'd2048) begin
        m = 80'd1024;
        e = e + 1;
      end
      inex = (r != 0);
      if (e >= 31) begin
        res = {x[79], 5'h1f, 10'd0};
        ovf = 1'b1;
        inex = 1'b1;
      end else begin
        res = {x[79], e[4:0], m[9:0]};
      end
    end
  endtask

  // Entered and left at #1 after a rising edge.
  task automatic do_op(input logic [79:0] x, input string tag, input int hold, input bit chk_lat);
    logic [15:0] e_res;
    logic e_ovf, e_inex;
    int e_lat, edges, g;
    model(x, e_res, e_ovf, e_inex, e_lat);
    g = 0;
    while (!in_ready_o && g < 200) begin
      @(posedge clk_i); #1; g++;
    end
    check({tag, " in_ready"}, 64'(in_ready_o), 64'd1);
    in_valid_i = 1'b1;
    fixed_point_value_i = x;
    @(posedge clk_i);
    edges = 1;
    #1;
    in_valid_i = 1'b0;
    while (!out_valid_o && edges < 200) begin
      @(posedge clk_i); edges++; #1;
    end
    if (chk_lat) check({tag, " latency"}, 64'(edges), 64'(e_lat));
    else check({tag, " out_valid"}, 64'(out_valid_o), 64'd1);
    check({tag, " result"}, 64'(float_point_operand_o), 64'(e_res));
    check({tag, " flags"}, 64'({overflow_flag_o, inexact_flag_o}), 64'({e_ovf, e_inex}));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk_i); #1;
      check({tag, " hold"},
            64'({out_valid_o, in_ready_o, overflow_flag_o, inexact_flag_o, float_point_operand_o}),
            64'({1'b1, 1'b0, e_ovf, e_inex, e_res}));
    end
    out_ready_i = 1'b1;
    @(posedge clk_i); #1;
    out_ready_i = 1'b0;
    check({tag, " valid fall"}, 64'(out_valid_o), 64'd0);
  endtask

  initial begin
    logic [95:0] rnd;
    logic [79:0] x;
    logic [79:0] v;

    repeat (2) @(posedge clk_i);
    #1;
    check("reset outs",
          64'({out_valid_o, overflow_flag_o, inexact_flag_o, float_point_operand_o}), 64'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    @(posedge clk_i); #1;
    check("reset in_ready", 64'(in_ready_o), 64'd1);

    // Directed cases, each compared against the model.
    v = 80'd1 << 24;                 do_op(v, "one", 0, 1'b1);
    check("one literal", 64'(float_point_operand_o), 64'h3C00);
    v = 80'd3 << 23; v = ~v + 80'd1; do_op(v, "neg1p5", 0, 1'b1);
    check("neg1p5 literal", 64'(float_point_operand_o), 64'hBE00);
    v = 80'd1;                       do_op(v, "min_denorm", 0, 1'b1);
    check("min_denorm literal", 64'(float_point_operand_o), 64'h0001);
    v = 80'd0;                       do_op(v, "zero", 0, 1'b1);
    v = '1;                          do_op(v, "neg_denorm", 0, 1'b1);
    check("neg_denorm literal", 64'(float_point_operand_o), 64'h8001);
    v = 80'd65520 << 24;             do_op(v, "rne_ovf", 0, 1'b1);
    check("rne_ovf literal",
          64'({overflow_flag_o, inexact_flag_o, float_point_operand_o}), 64'({2'b11, 16'h7C00}));
    v = 80'd1 << 79;                 do_op(v, "most_neg", 0, 1'b1);
    check("most_neg literal",
          64'({overflow_flag_o, float_point_operand_o}), 64'({1'b1, 16'hFC00}));
    v = 80'd2049 << 24;              do_op(v, "tie_even", 0, 1'b1);
    check("tie_even literal",
          64'({inexact_flag_o, float_point_operand_o}), 64'({1'b1, 16'h6800}));
    v = 80'd2051 << 24;              do_op(v, "tie_odd", 0, 1'b1);
    check("tie_odd literal",
          64'({inexact_flag_o, float_point_operand_o}), 64'({1'b1, 16'h6802}));
    v = 80'd1023;                    do_op(v, "max_denorm", 0, 1'b1);
    v = 80'd1024;                    do_op(v, "min_normal", 0, 1'b1);
    v = 80'd5 << 30;                 do_op(v, "backpressure", 10, 1'b1);

    // Reset in the middle of normalisation.
    in_valid_i = 1'b1;
    fixed_point_value_i = 80'd1 << 24;
    @(posedge clk_i); #1;
    in_valid_i = 1'b0;
    repeat (5) @(posedge clk_i);
    #1;
    rst_i = 1'b1;
    #2;
    check("rst abort outs",
          64'({out_valid_o, overflow_flag_o, inexact_flag_o, float_point_operand_o}), 64'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    @(posedge clk_i); #1;
    check("rst abort in_ready", 64'(in_ready_o), 64'd1);
    repeat (3) @(posedge clk_i);
    #1;
    check("rst abort no result", 64'(out_valid_o), 64'd0);
    v = 80'd7 << 40;                 do_op(v, "after_rst", 0, 1'b1);

    // Randomised operands spanning the full magnitude range.
    for (int n = 0; n < 60; n++) begin
      rnd = {$urandom, $urandom, $urandom};
      x = rnd[79:0];
      x = $signed(x) >>> $urandom_range(0, 79);
      do_op(x, "random", $urandom_range(0, 2), 1'b1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
